// File: rtl/instr_fetch.sv
// Fetch stage: a small instruction memory walked by a PC, presenting one word at a time
// over valid/ready. Jumps and the halt word are consumed here and never leave the stage.
module instr_fetch #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_WIDTH   = 5,
  parameter int RESET_PC   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic [31:0]         load_data,
  input  logic                start,
  input  logic                instr_ready,
  output logic                instr_valid,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         issue_count
);

  localparam logic [31:0]         HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [5:0]          J_OPCODE  = 6'b010100;
  localparam logic [PC_WIDTH-1:0] PC_INIT   = PC_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t               state_reg, state_next;
  logic [PC_WIDTH-1:0]  pc_reg, pc_next;
  logic [31:0]          instr_reg, instr_next;
  logic                 valid_reg, valid_next;
  logic [15:0]          count_reg, count_next;

  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] word;
  logic        advance;

  assign word    = mem[pc_reg];
  assign advance = !valid_reg || instr_ready;

  // Program memory is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge clk) begin
    if (load_en && state_reg != RUN) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= PC_INIT;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    count_next = count_reg;

    if (valid_reg && instr_ready && count_reg != 16'hFFFF) begin
      count_next = count_reg + 16'd1;
    end

    case (state_reg)
      IDLE, HALT: begin
        if (start) begin
          pc_next    = PC_INIT;
          count_next = '0;
          valid_next = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (advance) begin
          if (word == HALT_WORD) begin
            valid_next = 1'b0;
            state_next = HALT;
          end else if (word[31:26] == J_OPCODE) begin
            // The jump slot itself becomes the single bubble.
            pc_next    = word[PC_WIDTH-1:0];
            valid_next = 1'b0;
          end else begin
            instr_next = word;
            valid_next = 1'b1;
            pc_next    = pc_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign instr_valid = valid_reg;
  assign instruction = instr_reg;
  assign pc          = pc_reg;
  assign busy        = (state_reg == RUN);
  assign halted      = (state_reg == HALT);
  assign issue_count = count_reg;

endmodule
